uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter OSR, default 16, oversample ticks per bit (fixed 16; other values out of scope).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_i  input  1  raw UART pin, asynchronous to clk_i.
REQ-006 SHALL have port rx_en_i  input  1  receiver enable.
REQ-007 SHALL have port baud_div_i  input  16  clk_i cycles per oversample tick, minus 1.
REQ-008 SHALL have port rdata_o  output  8  FIFO head byte.
REQ-009 SHALL have port rvalid_o  output  1  FIFO non-empty.
REQ-010 SHALL have port rready_i  input  1  consumer accepts the head byte.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun_o  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-013 SHALL have port parity_err_o  output  1  one-cycle pulse on parity mismatch; constant 0 without the parity feature.
REQ-014 SHALL have port busy_o  output  1  FSM not in IDLE.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer whose flops reset to 1.
REQ-016 SHALL run a tick counter from 0 to baud_div_i, pulsing tick and reloading 0 on equality; the counter SHALL hold at 0 while in IDLE.
REQ-017 SHALL have FSM states IDLE, START, DATA, PARITY and STOP; PARITY SHALL exist only with the parity feature.
REQ-018 SHALL go IDLE->START on synced rx = 0 while rx_en_i = 1, clearing the sample counter (0..15, advanced per tick).
REQ-019 SHALL resolve each bit value by majority of the samples at counts 7, 8 and 9, decided at count 9.
REQ-020 SHALL, in START, return to IDLE on a majority of 1 (false start, no error flag); otherwise it SHALL enter DATA at count 15.
REQ-021 SHALL, in DATA, shift in 8 bits LSB first, each moving on at count 15; after bit 7 it SHALL enter PARITY if present, else STOP.
REQ-022 SHALL, in STOP, decide at count 9 and return to IDLE in the same cycle.
REQ-023 SHALL, on stop = 0, pulse frame_err_o and discard the byte.
REQ-024 SHALL, on stop = 1, push the byte into the FIFO.
REQ-025 SHALL, on a push with the FIFO full, drop the byte, pulse overrun_o and leave the FIFO contents unchanged.
REQ-026 SHALL treat a push and a pop (rvalid_o & rready_i) in the same cycle on a full FIFO as both accepted, with no overrun.
REQ-027 SHALL assert rvalid_o one cycle after the push cycle and keep rdata_o stable until popped.
REQ-028 SHALL, when rx_en_i falls mid-frame, force IDLE on the next edge, discard the partial byte and keep the FIFO.
REQ-029 SHALL apply a baud_div_i change at the next tick reload; a change mid-frame SHALL carry no behaviour guarantee.
REQ-030 SHALL keep FIFO pointers of width log2(FIFO_DEPTH)+1 that wrap modulo 2*FIFO_DEPTH; full when MSBs differ and LSBs are equal.

Reset
REQ-031 SHALL, while rst_ni = 0, immediately force FSM = IDLE, FIFO empty, rvalid_o = 0, rdata_o = 0x00, all error pulses 0, busy_o = 0 and the synchronizer to 1.
REQ-032 SHALL, on a reset mid-frame, drop the partial byte and receive no data until the next falling edge after reset release.

Configuration
REQ-033 SHALL, with UART_PARITY_EN defined, receive 11-bit even-parity frames; on a mismatch it SHALL pulse parity_err_o in the STOP decision cycle, not push the byte, and still check stop.
REQ-034 SHALL, without UART_PARITY_EN, receive 10-bit 8N1 frames, remove PARITY state logic entirely and tie parity_err_o to 0.

Structure
REQ-035 SHALL place the FSM state enum and bit/sample-count constants (OSR, MID_SAMPLE = 9, DATA_BITS = 8) in a shared package uart_pkg.
REQ-036 SHALL implement the FIFO as sub-module sync_fifo (parameterized width and depth, push/pop/full/empty).

Verification
REQ-037 SHALL cover: baud_div = 0, rx sends 0xA5 -> rdata_o = 0xA5, rvalid_o high within 160 cycles of the falling edge.
REQ-038 SHALL cover: a 5-cycle low glitch at baud_div = 0 -> return to IDLE, no rvalid_o, no errors.
REQ-039 SHALL cover: a frame 0x3C with stop = 0 -> one frame_err_o pulse, FIFO still empty.
REQ-040 SHALL cover: rready_i = 0, 5 bytes sent with depth 4 -> first 4 bytes retained in order, one overrun_o on the 5th.
REQ-041 SHALL cover: rst_ni pulsed low after bit 3 of 0xFF -> no push, busy_o = 0; the next frame 0x12 is received correctly.
REQ-042 SHALL cover, with UART_PARITY_EN: 0x07 sent with parity = 0 -> parity_err_o pulse, no push; parity = 1 -> 0x07 pushed.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : receiver FSM encoding and bit/sample constants (UART_PARITY_EN adds PARITY)
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OSR        = 16;
  localparam int MID_SAMPLE = 9;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with wrap-bit pointers; head word reads 0 when empty
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_push, w_do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still takes the push
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (w_do_push) wr_d = wr_q + (AW+1)'(1);
    if (w_do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo : 16x oversampled UART receiver feeding a byte FIFO (UART_PARITY_EN = 8E1)
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int OSR        = uart_pkg::OSR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  input  logic        rx_en_i,
  input  logic [15:0] baud_div_i,
  output logic [7:0]  rdata_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        parity_err_o,
  output logic        busy_o
);

  import uart_pkg::*;

  localparam int            SW        = $clog2(OSR);
  localparam logic [SW-1:0] SAMP_A    = SW'(MID_SAMPLE - 2);
  localparam logic [SW-1:0] SAMP_B    = SW'(MID_SAMPLE - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OSR - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic [15:0]          div_cnt_q;
  rx_state_e            state_q;
  logic [SW-1:0]        samp_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 s_a_q, s_b_q;
  logic                 push_q, frame_err_q;
  logic                 w_rx, w_tick, w_bit, w_pop, w_full, w_empty;
`ifdef UART_PARITY_EN
  logic                 par_bad_q, parity_err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx_i};
  end
  assign w_rx = sync_q[1];

  // Divider parks at 0 in IDLE so the first START tick is aligned to the edge
  assign w_tick = (state_q != ST_IDLE) && (div_cnt_q == baud_div_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           div_cnt_q <= '0;
    else if (state_q == ST_IDLE || w_tick) div_cnt_q <= '0;
    else                                   div_cnt_q <= div_cnt_q + 16'd1;
  end

  assign w_bit = maj3(s_a_q, s_b_q, w_rx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      s_a_q       <= 1'b1;
      s_b_q       <= 1'b1;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (!rx_en_i) begin
        state_q <= ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        if (!w_rx) begin
          state_q <= ST_START;
          samp_q  <= '0;
        end
      end else if (w_tick) begin
        samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
        if (samp_q == SAMP_A) s_a_q <= w_rx;
        if (samp_q == SAMP_B) s_b_q <= w_rx;
        case (state_q)
          ST_START: begin
            if (samp_q == SAMP_MID && w_bit) begin
              state_q <= ST_IDLE;
            end else if (samp_q == SAMP_LAST) begin
              state_q <= ST_DATA;
              bit_q   <= '0;
            end
          end
          ST_DATA: begin
            if (samp_q == SAMP_MID) shift_q <= {w_bit, shift_q[DATA_BITS-1:1]};
            if (samp_q == SAMP_LAST) begin
              bit_q <= bit_q + 3'd1;
`ifdef UART_PARITY_EN
              if (bit_q == BIT_LAST) state_q <= ST_PARITY;
`else
              if (bit_q == BIT_LAST) state_q <= ST_STOP;
`endif
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            if (samp_q == SAMP_MID)  par_bad_q <= w_bit ^ (^shift_q);
            if (samp_q == SAMP_LAST) state_q   <= ST_STOP;
          end
`endif
          ST_STOP: begin
            if (samp_q == SAMP_MID) begin
              state_q     <= ST_IDLE;
              frame_err_q <= ~w_bit;
`ifdef UART_PARITY_EN
              parity_err_q <= par_bad_q;
              push_q       <= w_bit & ~par_bad_q;
`else
              push_q       <= w_bit;
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (w_pop),
    .rdata_o (rdata_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign rvalid_o    = ~w_empty;
  assign w_pop       = rvalid_o & rready_i;
  assign overrun_o   = push_q & w_full & ~w_pop;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef UART_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// tb_uart_rx_fifo : directed and randomized frames checked against a queue model of the receive FIFO
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        rx_en = 1'b0;
  logic        rready = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic [7:0]  rdata;
  logic        rvalid, frame_err, overrun, parity_err, busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .OSR        (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (rx),
    .rx_en_i      (rx_en),
    .baud_div_i   (baud_div),
    .rdata_o      (rdata),
    .rvalid_o     (rvalid),
    .rready_i     (rready),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .parity_err_o (parity_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_cyc();
    return 16 * (int'(baud_div) + 1);
  endfunction

  // Drives the first nbits of a frame (start, data LSB first, [parity], stop), then idles the line high
  task automatic send_bits(input logic [7:0] b, input logic stop_b, input logic par_b, input int nbits);
    logic [10:0] fr;
    int          nf;
`ifdef UART_PARITY_EN
    fr = {stop_b, par_b, b, 1'b0};
    nf = 11;
`else
    fr = {par_b, stop_b, b, 1'b0};
    nf = 10;
`endif
    for (int k = 0; k < nbits && k < nf; k++) begin
      rx = fr[k];
      repeat (bit_cyc()) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    send_bits(b, stop_b, par_b, 99);
    repeat (bit_cyc()) @(negedge clk);
  endtask

  task automatic pop();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    int         cyc;
    int         base_fe, base_ov, base_pe;
    int         exp_fe, exp_ov;
    logic       good;
    logic [7:0] b;
    logic [7:0] arr [5];

    repeat (3) @(negedge clk);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 at the fastest rate, latency from the falling edge
    baud_div = 16'd0;
    cyc = -1;
    b = 8'hA5;
    fork
      send_frame(b, 1'b1, ^b);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(negedge clk);
          if (cyc < 0 && rvalid) cyc = i;
        end
      end
    join
    check("a5_latency_ok", (cyc > 0 && cyc <= 160), 1);
    check("a5_data", rdata, 8'hA5);
    pop();
    check("a5_popped", rvalid, 0);

    // short low glitch is a false start
    base_fe = fe_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_rvalid", rvalid, 0);
    check("glitch_frame_err", fe_cnt - base_fe, 0);

    // bad stop bit
    base_fe = fe_cnt;
    b = 8'h3C;
    send_frame(b, 1'b0, ^b);
    repeat (40) @(negedge clk);
    check("stop0_frame_err", fe_cnt - base_fe, 1);
    check("stop0_rvalid", rvalid, 0);
    check("stop0_busy", busy, 0);

    // five bytes into a four-deep FIFO with no consumer
    base_ov = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      arr[i] = 8'($urandom);
      send_frame(arr[i], 1'b1, ^arr[i]);
    end
    check("ovr_count", ov_cnt - base_ov, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_rvalid", rvalid, 1);
      check("ovr_data", rdata, arr[i]);
      pop();
    end
    check("ovr_drained", rvalid, 0);

    // receiver disabled mid-frame keeps earlier FIFO contents
    b = 8'h5A;
    send_frame(b, 1'b1, ^b);
    base_fe = fe_cnt;
    b = 8'hC3;
    send_bits(b, 1'b1, ^b, 5);
    rx_en = 1'b0;
    @(negedge clk);
    check("en_busy", busy, 0);
    @(negedge clk);
    rx_en = 1'b1;
    repeat (7 * bit_cyc()) @(negedge clk);
    check("en_rvalid", rvalid, 1);
    check("en_data", rdata, 8'h5A);
    check("en_frame_err", fe_cnt - base_fe, 0);

    // reset after bit 3 of 0xFF, FIFO (holding 0x5A) cleared
    b = 8'hFF;
    send_bits(b, 1'b1, ^b, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_rvalid", rvalid, 0);
    check("mrst_rdata", rdata, 0);
    rst_n = 1'b1;
    repeat (7 * bit_cyc()) @(negedge clk);
    check("mrst_after_busy", busy, 0);
    check("mrst_after_rvalid", rvalid, 0);
    b = 8'h12;
    send_frame(b, 1'b1, ^b);
    check("mrst_next_rvalid", rvalid, 1);
    check("mrst_next_data", rdata, 8'h12);
    pop();

`ifdef UART_PARITY_EN
    base_pe = pe_cnt;
    base_fe = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_pulse", pe_cnt - base_pe, 1);
    check("par_bad_rvalid", rvalid, 0);
    check("par_bad_frame_err", fe_cnt - base_fe, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_rvalid", rvalid, 1);
    check("par_ok_data", rdata, 8'h07);
    check("par_ok_pulse", pe_cnt - base_pe, 1);
    pop();
`else
    base_pe = 0;
    check("par_never", pe_cnt - base_pe, 0);
`endif

    // randomized frames, rates, bad stops and sporadic pops against a queue model
    exp_q.delete();
    exp_fe  = 0;
    exp_ov  = 0;
    base_fe = fe_cnt;
    base_ov = ov_cnt;
    for (int n = 0; n < 14; n++) begin
      baud_div = 16'($urandom_range(0, 3));
      b        = 8'($urandom);
      good     = ($urandom_range(0, 4) != 0);
      send_frame(b, good, ^b);
      if (!good)                       exp_fe++;
      else if (exp_q.size() == DEPTH)  exp_ov++;
      else                             exp_q.push_back(b);
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        check("rnd_rvalid", rvalid, 1);
        check("rnd_data", rdata, exp_q[0]);
        void'(exp_q.pop_front());
        pop();
      end
    end
    while (exp_q.size() > 0) begin
      check("rnd_drain_rvalid", rvalid, 1);
      check("rnd_drain_data", rdata, exp_q[0]);
      void'(exp_q.pop_front());
      pop();
    end
    check("rnd_empty", rvalid, 0);
    check("rnd_frame_errs", fe_cnt - base_fe, exp_fe);
    check("rnd_overruns", ov_cnt - base_ov, exp_ov);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
